axi_mem_responder: RTL and testbench

AXI4 slave memory responder that terminates the AXI master port of the external-memory subsystem's L2 cache; it is the DDR stand-in for simulation and for FPGA builds without DDR. It services INCR bursts into an internal word array. One transaction is in flight at a time, with fair arbitration between the read and write address channels.

---
 rtl/axi_mem_responder.sv | 228 ++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory responder: services INCR bursts into an internal word
// array, one transaction at a time, with alternating priority between the
// read and write address channels. Used as a DDR stand-in.
module axi_mem_responder #(
    parameter int AXI_ID_W   = 1,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32,
    parameter int MEM_ADDR_W = 16
) (
    input  logic                    clk_i,
    input  logic                    cke_i,
    input  logic                    arst_i,
    input  logic [AXI_ID_W-1:0]     axi_awid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
    input  logic                    axi_awvalid_i,
    output logic                    axi_awready_o,
    input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
    input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
    input  logic                    axi_wlast_i,
    input  logic                    axi_wvalid_i,
    output logic                    axi_wready_o,
    output logic [AXI_ID_W-1:0]     axi_bid_o,
    output logic [1:0]              axi_bresp_o,
    output logic                    axi_bvalid_o,
    input  logic                    axi_bready_i,
    input  logic [AXI_ID_W-1:0]     axi_arid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
    input  logic                    axi_arvalid_i,
    output logic                    axi_arready_o,
    output logic [AXI_ID_W-1:0]     axi_rid_o,
    output logic [AXI_DATA_W-1:0]   axi_rdata_o,
    output logic [1:0]              axi_rresp_o,
    output logic                    axi_rlast_o,
    output logic                    axi_rvalid_o,
    input  logic                    axi_rready_i
);

    localparam int NBYTES = AXI_DATA_W / 8;
    localparam int B      = $clog2(NBYTES);
    localparam int DEPTH  = 2 ** MEM_ADDR_W;

    typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;

    state_t                  state_q, state_d;
    logic                    en_q;
    logic                    prio_wr_q, prio_wr_d;
    logic [AXI_ID_W-1:0]     id_q, id_d;
    logic [MEM_ADDR_W-1:0]   idx_q, idx_d;
    logic [AXI_LEN_W-1:0]    cnt_q, cnt_d;
    logic                    err_q, err_d;

    logic                    aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last;
    logic [1:0]              b_resp;
    logic                    aw_hs, ar_hs, w_hs, b_hs, r_hs;
    logic                    rd_en;
    logic [MEM_ADDR_W-1:0]   rd_addr;
    logic [MEM_ADDR_W-1:0]   aw_idx, ar_idx;
    logic [AXI_DATA_W-1:0]   rdata;
    logic                    unused_addr;

    // Only the word-index bits of the byte address matter; the rest alias.
    assign aw_idx      = axi_awaddr_i[MEM_ADDR_W+B-1:B];
    assign ar_idx      = axi_araddr_i[MEM_ADDR_W+B-1:B];
    assign unused_addr = ^{axi_awaddr_i, axi_araddr_i};

    // A handshake only takes effect on an enabled clock edge.
    assign aw_hs = cke_i & axi_awvalid_i & aw_ready;
    assign ar_hs = cke_i & axi_arvalid_i & ar_ready;
    assign w_hs  = cke_i & axi_wvalid_i  & w_ready;
    assign b_hs  = cke_i & b_valid & axi_bready_i;
    assign r_hs  = cke_i & r_valid & axi_rready_i;

    // Read port: first beat fetched at AR accept, later beats prefetched on
    // each R handshake so consecutive beats issue without a bubble.
    assign rd_en   = ar_hs | (r_hs & (cnt_q != '0));
    assign rd_addr = (state_q == IDLE) ? ar_idx : idx_q + MEM_ADDR_W'(1);

    // State register and transaction context; everything holds while cke_i is low.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= IDLE;
            en_q      <= 1'b0;
            prio_wr_q <= 1'b1;
            id_q      <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else if (cke_i) begin
            state_q   <= state_d;
            en_q      <= 1'b1;
            prio_wr_q <= prio_wr_d;
            id_q      <= id_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic: arbitration, burst counting and error tracking.
    always_comb begin
        state_d   = state_q;
        prio_wr_d = prio_wr_q;
        id_d      = id_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    state_d   = WR_DATA;
                    id_d      = axi_awid_i;
                    idx_d     = aw_idx;
                    cnt_d     = axi_awlen_i;
                    err_d     = 1'b0;
                    prio_wr_d = 1'b0;
                end else if (ar_hs) begin
                    state_d   = RD_DATA;
                    id_d      = axi_arid_i;
                    idx_d     = ar_idx;
                    cnt_d     = axi_arlen_i;
                    prio_wr_d = 1'b1;
                end
            end
            WR_DATA: begin
                if (w_hs) begin
                    if (cnt_q == '0) begin
                        // Final counted beat; a missing wlast is flagged but the burst completes.
                        state_d = WR_RESP;
                        err_d   = err_q | ~axi_wlast_i;
                    end else if (axi_wlast_i) begin
                        // Master ended the burst early.
                        state_d = WR_RESP;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - AXI_LEN_W'(1);
                        idx_d = idx_q + MEM_ADDR_W'(1);
                    end
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_d = IDLE;
                end
            end
            RD_DATA: begin
                if (r_hs) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - AXI_LEN_W'(1);
                        idx_d = idx_q + MEM_ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the current state; readies are gated by en_q.
    always_comb begin
        aw_ready = 1'b0;
        ar_ready = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        b_resp   = 2'b00;
        r_valid  = 1'b0;
        r_last   = 1'b0;
        case (state_q)
            IDLE: begin
                aw_ready = en_q & (~axi_arvalid_i | prio_wr_q);
                ar_ready = en_q & (~axi_awvalid_i | ~prio_wr_q);
            end
            WR_DATA: w_ready = en_q;
            WR_RESP: begin
                b_valid = 1'b1;
                b_resp  = err_q ? 2'b10 : 2'b00;
            end
            RD_DATA: begin
                r_valid = 1'b1;
                r_last  = (cnt_q == '0);
            end
            default: ;
        endcase
    end

    // One byte-wide array per lane keeps strobed writes simple and maps to block RAM.
    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] rd_q;

            // Strobed write of this lane; contents survive reset.
            always_ff @(posedge clk_i) begin
                if (w_hs && axi_wstrb_i[gi]) begin
                    lane_mem[idx_q] <= axi_wdata_i[gi*8 +: 8];
                end
            end

            // Registered read of this lane, held while the beat is stalled.
            always_ff @(posedge clk_i or posedge arst_i) begin
                if (arst_i) begin
                    rd_q <= '0;
                end else if (rd_en) begin
                    rd_q <= lane_mem[rd_addr];
                end
            end

            assign rdata[gi*8 +: 8] = rd_q;
        end
    endgenerate

    assign axi_awready_o = aw_ready;
    assign axi_arready_o = ar_ready;
    assign axi_wready_o  = w_ready;
    assign axi_bvalid_o  = b_valid;
    assign axi_bresp_o   = b_resp;
    assign axi_bid_o     = id_q;
    assign axi_rvalid_o  = r_valid;
    assign axi_rlast_o   = r_last;
    assign axi_rid_o     = id_q;
    assign axi_rdata_o   = rdata;
    assign axi_rresp_o   = 2'b00;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Bench for axi_mem_responder: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level memory model.
module tb_axi_mem_responder;

    localparam int DEPTH = 1 << 16;

    logic        clk = 1'b0;
    logic        cke = 1'b1;
    logic        arst = 1'b1;
    logic [0:0]  awid = '0, arid = '0, bid, rid;
    logic [23:0] awaddr = '0, araddr = '0;
    logic [7:0]  awlen = '0, arlen = '0;
    logic        awvalid = 1'b0, awready;
    logic [31:0] wdata = '0, rdata;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0, wvalid = 1'b0, wready;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready = 1'b0;
    logic        arvalid = 1'b0, arready;
    logic        rlast, rvalid, rready = 1'b0;

    axi_mem_responder dut (
        .clk_i(clk), .cke_i(cke), .arst_i(arst),
        .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen),
        .axi_awvalid_i(awvalid), .axi_awready_o(awready),
        .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast),
        .axi_wvalid_i(wvalid), .axi_wready_o(wready),
        .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
        .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen),
        .axi_arvalid_i(arvalid), .axi_arready_o(arready),
        .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rlast_o(rlast),
        .axi_rvalid_o(rvalid), .axi_rready_i(rready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {logic id; logic [31:0] data; logic last;} rbeat_t;
    typedef struct packed {logic id; logic [1:0] resp;} bresp_t;

    logic [31:0] mmem [int];
    rbeat_t      r_q[$];
    bresp_t      b_q[$];
    bit          in_wr = 0;
    bit          prio_m = 1;
    bit          en_m = 0;
    int          wr_idx, wr_rem;
    logic        wr_id;
    int          grant_log[$];
    bit          cke_rand = 0;

    function automatic int idx_of(input logic [23:0] a);
        return int'(a >> 2) % DEPTH;
    endfunction

    // Model of the enable flag: off in reset, on after the first enabled edge.
    always @(posedge clk or posedge arst) begin
        if (arst) en_m <= 1'b0;
        else if (cke) en_m <= 1'b1;
    end

    // Compare process: checks outputs against the model, then advances the
    // model with the handshakes that the coming edge will complete.
    always @(negedge clk) begin : mon
        bit busy;
        logic [31:0] v;
        if (arst) begin
            chk("reset_outputs", {awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, bid, rid, rdata}, 64'd0);
            r_q.delete();
            b_q.delete();
            in_wr  = 0;
            prio_m = 1;
        end else begin
            busy = in_wr || (b_q.size() != 0) || (r_q.size() != 0);
            chk("awready", awready, en_m && !busy && (!arvalid || prio_m));
            chk("arready", arready, en_m && !busy && (!awvalid || !prio_m));
            chk("wready", wready, in_wr && en_m);
            chk("both_granted", awvalid && awready && arvalid && arready, 0);
            chk("bvalid", bvalid, b_q.size() != 0);
            if (b_q.size() != 0) begin
                chk("bid", bid, b_q[0].id);
                chk("bresp", bresp, b_q[0].resp);
            end
            chk("rvalid", rvalid, r_q.size() != 0);
            if (r_q.size() != 0) begin
                chk("rid", rid, r_q[0].id);
                chk("rdata", rdata, r_q[0].data);
                chk("rlast", rlast, r_q[0].last);
                chk("rresp", rresp, 2'b00);
            end
            if (cke) begin
                if (bvalid && bready && b_q.size() != 0) void'(b_q.pop_front());
                if (rvalid && rready && r_q.size() != 0) void'(r_q.pop_front());
                if (wvalid && wready && in_wr) begin
                    v = mmem.exists(wr_idx) ? mmem[wr_idx] : 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (wstrb[b]) v[8*b +: 8] = wdata[8*b +: 8];
                    mmem[wr_idx] = v;
                    if (wr_rem == 0 || wlast) begin
                        b_q.push_back('{wr_id, (wr_rem != 0 || !wlast) ? 2'b10 : 2'b00});
                        in_wr = 0;
                    end else begin
                        wr_rem--;
                        wr_idx = (wr_idx + 1) % DEPTH;
                    end
                end
                if (awvalid && awready) begin
                    in_wr  = 1;
                    wr_id  = awid;
                    wr_idx = idx_of(awaddr);
                    wr_rem = int'(awlen);
                    prio_m = 0;
                    grant_log.push_back(1);
                end else if (arvalid && arready) begin
                    for (int i = 0; i <= int'(arlen); i++) begin
                        int k;
                        k = (idx_of(araddr) + i) % DEPTH;
                        r_q.push_back('{arid, mmem.exists(k) ? mmem[k] : 32'h0, i == int'(arlen)});
                    end
                    prio_m = 1;
                    grant_log.push_back(0);
                end
            end
        end
    end

    // Optional random clock-enable gaps.
    initial forever begin
        @(posedge clk);
        #1;
        cke = cke_rand ? ($urandom_range(0, 5) != 0) : 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- agents ----------------
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rcap [16];

    task automatic wait_ch(input int ch, input string nm);
        int  n;
        bit  hit;
        n = 0;
        hit = 0;
        while (!hit && n < 300) begin
            @(negedge clk);
            n++;
            case (ch)
                0: hit = awready && cke;
                1: hit = wready && cke;
                2: hit = bvalid && cke;
                default: hit = arready && cke;
            endcase
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL timeout_%s: got no handshake, required one within 300 cycles", nm);
        end
    endtask

    task automatic wr_txn(input logic id, input logic [23:0] addr, input int len, input int nbeats,
                          input bit nolast, input int bdelay, input bit gaps, output logic [1:0] resp);
        @(posedge clk);
        #1;
        awid = id; awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
        wait_ch(0, "aw");
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            wvalid = 1'b1; wdata = wd[b]; wstrb = ws[b];
            wlast = (b == nbeats - 1) && !nolast;
            wait_ch(1, "w");
            @(posedge clk);
            #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        for (int k = 0; k < bdelay; k++) begin
            @(posedge clk);
            #1;
        end
        bready = 1'b1;
        wait_ch(2, "b");
        resp = bresp;
        @(posedge clk);
        #1;
        bready = 1'b0;
    endtask

    task automatic rd_txn(input logic id, input logic [23:0] addr, input int len, input bit rrand);
        int got, n;
        @(posedge clk);
        #1;
        arid = id; araddr = addr; arlen = 8'(len); arvalid = 1'b1;
        wait_ch(3, "ar");
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        got = 0;
        n = 0;
        while (got <= len && n < 400) begin
            rready = rrand ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(negedge clk);
            if (rvalid && rready && cke) begin
                rcap[got % 16] = rdata;
                got++;
            end
            @(posedge clk);
            #1;
            n++;
        end
        rready = 1'b0;
        if (got <= len) begin
            total++;
            bad++;
            $display("FAIL timeout_r: got %0d beats, required %0d", got, len + 1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0]  resp, resp2;
        int          got, n;
        repeat (3) @(posedge clk);
        #1;
        arst = 1'b0;

        // Single write then read.
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        wr_txn(1'b0, 24'h000040, 0, 1, 0, 0, 0, resp);
        chk("t1_bresp", resp, 2'b00);
        rd_txn(1'b0, 24'h000040, 0, 0);
        chk("t1_rdata", rcap[0], 32'hDEADBEEF);

        // 8-beat line fill.
        for (int i = 0; i < 8; i++) begin wd[i] = 32'(i); ws[i] = 4'hF; end
        wr_txn(1'b1, 24'h000100, 7, 8, 0, 0, 0, resp);
        rd_txn(1'b1, 24'h000100, 7, 0);
        for (int i = 0; i < 8; i++) chk("t2_rdata", rcap[i], 32'(i));

        // Strobes and backpressure.
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        wr_txn(1'b0, 24'h000200, 0, 1, 0, 0, 0, resp);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'h3;
        wr_txn(1'b1, 24'h000200, 0, 1, 0, 5, 0, resp);
        chk("t3_bresp", resp, 2'b00);
        rd_txn(1'b0, 24'h000200, 0, 1);
        chk("t3_rdata", rcap[0], 32'h1122CCDD);

        // Contending address channels, three rounds.
        grant_log.delete();
        for (int r = 0; r < 3; r++) begin
            wd[0] = 32'hC0DE0000 + 32'(r); ws[0] = 4'hF;
            fork
                wr_txn(1'b1, 24'h000300 + 24'(4 * r), 0, 1, 0, 0, 0, resp2);
                rd_txn(1'b0, 24'h000040, 0, 0);
            join
        end
        chk("arb_count", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk("arb_order", grant_log[i], (i % 2 == 0) ? 1 : 0);

        // Early wlast and missing wlast.
        wd[0] = 32'h01010101; wd[1] = 32'h02020202; ws[0] = 4'hF; ws[1] = 4'hF;
        wr_txn(1'b0, 24'h000400, 3, 2, 0, 0, 0, resp);
        chk("early_wlast_bresp", resp, 2'b10);
        wr_txn(1'b1, 24'h000410, 1, 2, 1, 0, 0, resp);
        chk("no_wlast_bresp", resp, 2'b10);
        rd_txn(1'b0, 24'h000400, 1, 0);

        // Index wrap at the top of the array.
        wd[0] = 32'hA5A50001; wd[1] = 32'h5A5A0002;
        wr_txn(1'b1, 24'h03FFFC, 1, 2, 0, 0, 0, resp);
        chk("wrap_bresp", resp, 2'b00);
        rd_txn(1'b0, 24'hC00000, 0, 0);
        chk("wrap_idx0", rcap[0], 32'h5A5A0002);
        rd_txn(1'b1, 24'h03FFFC, 1, 0);
        chk("wrap_rd0", rcap[0], 32'hA5A50001);
        chk("wrap_rd1", rcap[1], 32'h5A5A0002);

        // Fill indices 0..63 so random reads only see written words.
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            wr_txn(1'b0, 24'(blk * 64), 15, 16, 0, 0, 0, resp);
        end

        // Randomized traffic with clock-enable gaps.
        cke_rand = 1;
        for (int t = 0; t < 40; t++) begin
            int op, wb, wl, rb, rl, nb;
            logic [23:0] wa, ra;
            op = $urandom_range(0, 2);
            wb = $urandom_range(0, 47); wl = $urandom_range(0, 15);
            rb = $urandom_range(0, 47); rl = $urandom_range(0, 15);
            wa = {6'($urandom), 16'(wb), 2'($urandom)};
            ra = {6'($urandom), 16'(rb), 2'($urandom)};
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            nb = (wl > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(1, wl) : wl + 1;
            case (op)
                0: wr_txn(1'($urandom), wa, wl, nb, 0, $urandom_range(0, 3), 1, resp);
                1: rd_txn(1'($urandom), ra, rl, 1);
                default: fork
                    wr_txn(1'($urandom), wa, wl, nb, 0, $urandom_range(0, 3), 1, resp);
                    rd_txn(1'($urandom), ra, rl, 1);
                join
            endcase
        end
        cke_rand = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of an 8-beat read.
        arid = 1'b1; araddr = 24'h000100; arlen = 8'd7; arvalid = 1'b1;
        wait_ch(3, "ar_rst");
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        rready = 1'b1;
        got = 0;
        n = 0;
        while (got < 3 && n < 50) begin
            @(negedge clk);
            if (rvalid && cke) got++;
            @(posedge clk);
            #1;
            n++;
        end
        chk("rst_beats_before", got, 3);
        arst = 1'b1;
        #1;
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_arready", arready, 1'b0);
        rready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        arid = 1'b0; araddr = 24'h000108; arlen = 8'd0; arvalid = 1'b1;
        arst = 1'b0;
        @(negedge clk);
        chk("post_rst_no_ready", arready, 1'b0);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        rd_txn(1'b0, 24'h000108, 0, 0);
        chk("post_rst_rdata", rcap[0], 32'd2);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
